// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction in flight; grant held from address phase to response handshake, round-robin on ties.
module axi_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_arvalid,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    output logic                    m0_arready,
    output logic                    m0_rvalid,
    output logic [1:0]              m0_rresp,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m0_rready,
    input  logic                    m1_arvalid,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    output logic                    m1_arready,
    output logic                    m1_rvalid,
    output logic [1:0]              m1_rresp,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    input  logic                    m1_rready,
    input  logic                    m1_awvalid,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    output logic                    m1_awready,
    input  logic                    m1_wvalid,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_wready,
    output logic                    m1_bvalid,
    output logic [1:0]              m1_bresp,
    input  logic                    m1_bready,
    output logic                    s_arvalid,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arready,
    input  logic                    s_rvalid,
    input  logic [1:0]              s_rresp,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    s_rready,
    output logic                    s_awvalid,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awready,
    output logic                    s_wvalid,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wready,
    input  logic                    s_bvalid,
    input  logic [1:0]              s_bresp,
    output logic                    s_bready,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, G_IF, G_LR, G_LW} state_e;

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   ifu_req, lsu_req;

    assign ifu_req = m0_arvalid;
    assign lsu_req = m1_awvalid | m1_arvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            ar_done_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            ar_done_q  <= ar_done_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // On a tie the master that was not served last wins; LSU writes beat LSU reads.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (ifu_req && (!lsu_req || last_gnt_q)) begin
                    state_d    = G_IF;
                    last_gnt_d = 1'b0;
                end else if (lsu_req) begin
                    state_d    = m1_awvalid ? G_LW : G_LR;
                    last_gnt_d = 1'b1;
                end
            end
            G_IF, G_LR: if (s_rvalid && s_rready) state_d = IDLE;
            G_LW:       if (s_bvalid && s_bready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        ar_done_d = ar_done_q | (s_arvalid & s_arready);
        aw_done_d = aw_done_q | (s_awvalid & s_awready);
        w_done_d  = w_done_q  | (s_wvalid & s_wready);
        if (state_d == IDLE) begin
            ar_done_d = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    // Pure passthrough routing; a completed address/data phase is masked so it cannot be reissued.
    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = m1_araddr;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        case (state_q)
            G_IF: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid & ~ar_done_q;
                m0_arready = s_arready & ~ar_done_q;
                s_rready   = m0_rready;
                m0_rvalid  = s_rvalid;
            end
            G_LR: begin
                s_arvalid  = m1_arvalid & ~ar_done_q;
                m1_arready = s_arready & ~ar_done_q;
                s_rready   = m1_rready;
                m1_rvalid  = s_rvalid;
            end
            G_LW: begin
                s_awvalid  = m1_awvalid & ~aw_done_q;
                m1_awready = s_awready & ~aw_done_q;
                s_wvalid   = m1_wvalid & ~w_done_q;
                m1_wready  = s_wready & ~w_done_q;
                s_bready   = m1_bready;
                m1_bvalid  = s_bvalid;
            end
            default: ;
        endcase
    end

    assign s_awaddr = m1_awaddr;
    assign s_wdata  = m1_wdata;
    assign s_wstrb  = m1_wstrb;
    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_bresp = s_bresp;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: the bench plays both masters and the slave step by step.
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;
    logic        busy;

    int nAsserts = 0;
    int nFails   = 0;
    int arHs = 0, awHs = 0, wHs = 0;
    int arBase, awBase, wBase;

    always #5 clk = ~clk;

    axi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .busy(busy)
    );

    // Slave-side handshake counters, used to prove no channel is issued twice.
    always @(posedge clk) begin
        if (!rst) begin
            if (s_arvalid && s_arready) arHs++;
            if (s_awvalid && s_awready) awHs++;
            if (s_wvalid && s_wready)   wHs++;
        end
    end

    // Advance n clock edges and step just past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every master-facing valid/ready, packed for one-shot checks.
    function automatic logic [6:0] m1Outs();
        return {m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid, 2'b00};
    endfunction

    initial begin
        rst = 1'b1;
        {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
        {m0_araddr, m1_araddr, m1_awaddr, m1_wdata, m1_wstrb} = '0;
        {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
        {s_rdata, s_rresp, s_bresp} = '0;

        // Reset state, with slave pushing valids that must stay hidden
        s_arready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
        applyStimulus(2);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_slave_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        checkOutput("rst_master_outs", {m0_arready, m0_rvalid, m1Outs()}, 0);
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        rst = 1'b0;
        applyStimulus(1);

        // IFU alone
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000;
        #1;
        checkOutput("ifu_idle_no_fwd", s_arvalid, 0);
        applyStimulus(1);
        checkOutput("ifu_busy1", busy, 1);
        checkOutput("ifu_s_arvalid", s_arvalid, 1);
        checkOutput("ifu_s_araddr", s_araddr, 64'h8000_0000);
        checkOutput("ifu_arready", m0_arready, 1);
        checkOutput("ifu_m1_quiet_ar", m1Outs(), 0);
        applyStimulus(1);
        m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0413; m0_rready = 1'b1;
        #1;
        checkOutput("ifu_rvalid", m0_rvalid, 1);
        checkOutput("ifu_rdata", m0_rdata, 64'h0000_0413);
        checkOutput("ifu_busy2", busy, 1);
        checkOutput("ifu_m1_quiet_r", m1Outs(), 0);
        applyStimulus(1);
        s_rvalid = 1'b0; m0_rready = 1'b0;
        #1;
        checkOutput("ifu_busy_drop", busy, 0);
        checkOutput("ifu_rvalid_drop", m0_rvalid, 0);

        // Tie after reset: IFU, LSU, IFU, LSU
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0A00;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0B00;
        applyStimulus(1);
        checkOutput("tie1_addr", s_araddr, 64'h0000_0A00);
        checkOutput("tie1_m0_arready", m0_arready, 1);
        checkOutput("tie1_m1_arready", m1_arready, 0);
        applyStimulus(1);
        m0_arvalid = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
        #1;
        checkOutput("tie1_rvalid", m0_rvalid, 1);
        applyStimulus(1);
        s_rvalid = 1'b0; m0_rready = 1'b0;
        #1;
        checkOutput("tie_idle_gap", {busy, m1_arready}, 0);
        applyStimulus(1);
        checkOutput("tie2_addr", s_araddr, 64'h0000_0B00);
        checkOutput("tie2_m1_arready", m1_arready, 1);
        applyStimulus(1);
        m1_arvalid = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1;
        #1;
        checkOutput("tie2_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        applyStimulus(1);
        s_rvalid = 1'b0; m1_rready = 1'b0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("tie3_ifu_wins", {m0_arready, m1_arready}, 2'b10);
        applyStimulus(1);
        m0_arvalid = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
        applyStimulus(1);
        s_rvalid = 1'b0; m0_rready = 1'b0;
        applyStimulus(1);
        checkOutput("tie4_lsu_wins", {m0_arready, m1_arready}, 2'b01);
        applyStimulus(1);
        m1_arvalid = 1'b0; s_rvalid = 1'b1; m1_rready = 1'b1;
        applyStimulus(1);
        s_rvalid = 1'b0; m1_rready = 1'b0;
        #1;
        checkOutput("tie_done_idle", busy, 0);

        // LSU write, W handshakes two cycles before AW, IFU blocked
        awBase = awHs; wBase = wHs;
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b1;
        m1_awvalid = 1'b1; m1_awaddr = 32'h8000_1000;
        m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b1111;
        applyStimulus(1);
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040;
        #1;
        checkOutput("wr_fwd", {s_awvalid, s_wvalid, m1_awready, m1_wready}, 4'b1101);
        checkOutput("wr_data", {s_wdata, 28'h0, s_wstrb}, {32'hDEAD_BEEF, 32'h0000_000F});
        checkOutput("wr_m0_blocked1", {m0_arready, s_arvalid}, 0);
        applyStimulus(1);
        s_wready = 1'b0;
        #1;
        checkOutput("wr_w_masked", s_wvalid, 0);
        applyStimulus(1);
        s_awready = 1'b1;
        #1;
        checkOutput("wr_aw", {s_awvalid, m1_awready}, 2'b11);
        checkOutput("wr_awaddr", s_awaddr, 64'h8000_1000);
        applyStimulus(1);
        s_awready = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00; m1_bready = 1'b1;
        #1;
        checkOutput("wr_bvalid", {m1_bvalid, s_bready, busy}, 3'b111);
        checkOutput("wr_m0_blocked2", {m0_arready, s_arvalid}, 0);
        m0_arvalid = 1'b0;
        applyStimulus(1);
        s_bvalid = 1'b0; m1_bready = 1'b0;
        #1;
        checkOutput("wr_release", busy, 0);
        checkOutput("wr_one_aw", awHs - awBase, 1);
        checkOutput("wr_one_w", wHs - wBase, 1);

        // Master holds arvalid while slave stalls R for 5 cycles
        arBase = arHs;
        s_arready = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0080;
        applyStimulus(1);
        checkOutput("stall_first_ar", s_arvalid, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("stall_masked_%0d", i), {s_arvalid, m0_arready, m0_rvalid}, 0);
        end
        m0_arvalid = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
        applyStimulus(1);
        s_rvalid = 1'b0; m0_rready = 1'b0;
        #1;
        checkOutput("stall_one_ar", arHs - arBase, 1);
        checkOutput("stall_idle", busy, 0);

        // Error response on an LSU read
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0FFC;
        applyStimulus(1);
        checkOutput("err_arready", m1_arready, 1);
        applyStimulus(1);
        m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rresp = 2'b10; m1_rready = 1'b1;
        #1;
        checkOutput("err_rresp", {m1_rvalid, m1_rresp}, 3'b110);
        applyStimulus(1);
        s_rvalid = 1'b0; s_rresp = 2'b00; m1_rready = 1'b0;
        #1;
        checkOutput("err_idle", busy, 0);

        // Reset in G_LW after AW/W but before B
        s_awready = 1'b1; s_wready = 1'b1;
        m1_awvalid = 1'b1; m1_awaddr = 32'h8000_2000; m1_wvalid = 1'b1;
        applyStimulus(2);
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b1;
        #1;
        checkOutput("mid_busy", busy, 1);
        rst = 1'b1; s_bvalid = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_outs", {m0_arready, m0_rvalid, m1Outs(), s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        rst = 1'b0; s_bvalid = 1'b0; m1_bready = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0100;
        applyStimulus(1);
        checkOutput("mid_ifu_grant", {m0_arready, s_arvalid, busy}, 3'b111);
        applyStimulus(1);
        m0_arvalid = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
        applyStimulus(1);
        s_rvalid = 1'b0; m0_rready = 1'b0;
        #1;
        checkOutput("mid_ifu_done", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
